univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 92 +++++++++
 tb/tb_univ_shift_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - N-stage, W-bit universal shift register with fill tracking
module univ_shift_reg #(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       rot,
  input  logic [W-1:0]               sin_r,
  input  logic [W-1:0]               sin_l,
  input  logic [N*W-1:0]             pdata,
  output logic [N*W-1:0]             pout,
  output logic [W-1:0]               sout_r,
  output logic [W-1:0]               sout_l,
  output logic [$clog2(N+1)-1:0]     fill,
  output logic                       full
);

  localparam int FW = $clog2(N+1);
  localparam logic [FW-1:0] FILL_MAX = FW'(N);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  // Packed so that stage i lands on bits [i*W +: W] of the flat bus.
  logic [N-1:0][W-1:0] stage_q;
  logic [N-1:0][W-1:0] stage_d;
  logic [FW-1:0]       fill_q;
  logic [FW-1:0]       fill_d;

  // Next-state for the stages and the fill counter; hold is the default.
  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (en) begin
      case (mode_t'(mode))
        MODE_HOLD: begin
          stage_d = stage_q;
          fill_d  = fill_q;
        end
        MODE_SHR: begin
          for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
          end
          stage_d[0] = rot ? stage_q[N-1] : sin_r;
          // Only fresh serial data counts toward fill; recirculation adds nothing.
          if (!rot && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + FW'(1);
          end
        end
        MODE_SHL: begin
          for (int i = 0; i < N-1; i++) begin
            stage_d[i] = stage_q[i+1];
          end
          stage_d[N-1] = rot ? stage_q[0] : sin_l;
          if (!rot && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + FW'(1);
          end
        end
        MODE_LOAD: begin
          stage_d = pdata;
          fill_d  = FILL_MAX;
        end
      endcase
    end
  end

  // State register; clear wipes everything immediately, without waiting for clk.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      stage_q <= '0;
      fill_q  <= '0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
    end
  end

  // Outputs come straight from registers so no input reaches an output combinationally.
  assign pout   = stage_q;
  assign sout_r = stage_q[N-1];
  assign sout_l = stage_q[0];
  assign fill   = fill_q;
  assign full   = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard bench for univ_shift_reg (N=4, W=1 and W=8)
module tb_univ_shift_reg;

  logic clk = 1'b0;
  logic clear = 1'b0;

  logic        en1 = 1'b0, rot1 = 1'b0, sinr1 = 1'b0, sinl1 = 1'b0;
  logic [1:0]  mode1 = 2'b00;
  logic [3:0]  pd1 = '0;
  logic [3:0]  pout1;
  logic        sr1, sl1, full1;
  logic [2:0]  fill1;

  logic        en8 = 1'b0, rot8 = 1'b0;
  logic [1:0]  mode8 = 2'b00;
  logic [7:0]  sinr8 = '0, sinl8 = '0;
  logic [31:0] pd8 = '0;
  logic [31:0] pout8;
  logic [7:0]  sr8, sl8;
  logic        full8;
  logic [2:0]  fill8;

  typedef struct {
    string       name;
    logic [31:0] pout;
    logic [2:0]  fill;
    logic        full;
    logic [7:0]  sr;
    logic [7:0]  sl;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  int total = 0;
  int bad = 0;

  univ_shift_reg #(.N(4), .W(1)) u_dut1 (
    .clk(clk), .clear(clear), .en(en1), .mode(mode1), .rot(rot1),
    .sin_r(sinr1), .sin_l(sinl1), .pdata(pd1),
    .pout(pout1), .sout_r(sr1), .sout_l(sl1), .fill(fill1), .full(full1)
  );

  univ_shift_reg #(.N(4), .W(8)) u_dut8 (
    .clk(clk), .clear(clear), .en(en8), .mode(mode8), .rot(rot8),
    .sin_r(sinr8), .sin_l(sinl8), .pdata(pd8),
    .pout(pout8), .sout_r(sr8), .sout_l(sl8), .fill(fill8), .full(full8)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk8(input string nm, input logic [31:0] p, input logic [2:0] f);
    exp_t e;
    e.name = nm; e.pout = p; e.fill = f; e.full = (f == 3'd4);
    e.sr = p[31:24]; e.sl = p[7:0];
    return e;
  endfunction

  function automatic exp_t mk1(input string nm, input logic [3:0] p, input logic [2:0] f);
    exp_t e;
    e.name = nm; e.pout = {28'd0, p}; e.fill = f; e.full = (f == 3'd4);
    e.sr = {7'd0, p[3]}; e.sl = {7'd0, p[0]};
    return e;
  endfunction

  // Monitor: outputs are presented after every clk edge and on every clear fall.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge clear);
      #1;
      if (q8.size() > 0) begin
        e = q8.pop_front();
        total++;
        if ({pout8, fill8, full8, sr8, sl8} !== {e.pout, e.fill, e.full, e.sr, e.sl}) begin
          bad++;
          $display("FAIL %s w8: got pout=%h fill=%0d full=%b sr=%h sl=%h want pout=%h fill=%0d full=%b sr=%h sl=%h",
                   e.name, pout8, fill8, full8, sr8, sl8, e.pout, e.fill, e.full, e.sr, e.sl);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        total++;
        if ({pout1, fill1, full1, sr1, sl1} !== {e.pout[3:0], e.fill, e.full, e.sr[0], e.sl[0]}) begin
          bad++;
          $display("FAIL %s w1: got pout=%b fill=%0d full=%b sr=%b sl=%b want pout=%b fill=%0d full=%b sr=%b sl=%b",
                   e.name, pout1, fill1, full1, sr1, sl1, e.pout[3:0], e.fill, e.full, e.sr[0], e.sl[0]);
        end
      end
    end
  end

  // One W=8 clock edge; called at a falling clk edge, returns at the next one.
  task automatic step8(input string nm, input logic e, input logic [1:0] m, input logic r,
                       input logic [7:0] s_r, input logic [7:0] s_l, input logic [31:0] pd,
                       input logic [31:0] ep, input logic [2:0] ef);
    clear = 1'b1;
    en1 = 1'b0;
    en8 = e; mode8 = m; rot8 = r; sinr8 = s_r; sinl8 = s_l; pd8 = pd;
    q8.push_back(mk8(nm, ep, ef));
    @(negedge clk);
  endtask

  // One W=1 clock edge.
  task automatic step1(input string nm, input logic [1:0] m, input logic r,
                       input logic s_r, input logic s_l, input logic [3:0] ep, input logic [2:0] ef);
    clear = 1'b1;
    en8 = 1'b0;
    en1 = 1'b1; mode1 = m; rot1 = r; sinr1 = s_r; sinl1 = s_l; pd1 = 4'hF;
    q1.push_back(mk1(nm, ep, ef));
    @(negedge clk);
  endtask

  // Clear pulse that lives entirely between two rising edges.
  task automatic clear_pulse(input string nm);
    en1 = 1'b0; en8 = 1'b0;
    q8.push_back(mk8(nm, 32'h0, 3'd0));
    q1.push_back(mk1(nm, 4'h0, 3'd0));
    #1 clear = 1'b0;
    #3 clear = 1'b1;
    @(negedge clk);
  endtask

  // Clear held low across a rising edge with a load requested on both DUTs.
  task automatic clear_hold(input string nm);
    q8.push_back(mk8({nm, "_fall"}, 32'h0, 3'd0));
    q1.push_back(mk1({nm, "_fall"}, 4'h0, 3'd0));
    #1 clear = 1'b0;
    en8 = 1'b1; mode8 = 2'b11; pd8 = 32'hFFFF_FFFF; sinr8 = 8'hFF; sinl8 = 8'hFF;
    en1 = 1'b1; mode1 = 2'b11; pd1 = 4'hF;
    #2;
    q8.push_back(mk8({nm, "_edge"}, 32'h0, 3'd0));
    q1.push_back(mk1({nm, "_edge"}, 4'h0, 3'd0));
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    q8.push_back(mk8("reset", 32'h0, 3'd0));
    q1.push_back(mk1("reset", 4'h0, 3'd0));
    @(negedge clk);

    // Serial-in/serial-out on the 1-bit instance: a single 1 walks to sout_r.
    step1("sisoe1", 2'b01, 1'b0, 1'b1, 1'b0, 4'b0001, 3'd1);
    step1("sisoe2", 2'b01, 1'b0, 1'b0, 1'b0, 4'b0010, 3'd2);
    step1("sisoe3", 2'b01, 1'b0, 1'b0, 1'b0, 4'b0100, 3'd3);
    step1("sisoe4", 2'b01, 1'b0, 1'b0, 1'b0, 4'b1000, 3'd4);
    step1("sisoe5", 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd4);
    step1("shl_w1", 2'b10, 1'b0, 1'b0, 1'b1, 4'b1000, 3'd4);
    step1("rotl_w1", 2'b10, 1'b1, 1'b0, 1'b0, 4'b0100, 3'd4);

    // Load, shift, rotate and hold on the 8-bit instance.
    step8("load", 1'b1, 2'b11, 1'b0, 8'h00, 8'h00, 32'h4433_2211, 32'h4433_2211, 3'd4);
    step8("shl_aa", 1'b1, 2'b10, 1'b0, 8'h00, 8'hAA, 32'h0, 32'hAA44_3322, 3'd4);
    step8("load_rot", 1'b1, 2'b11, 1'b1, 8'h00, 8'h00, 32'h4433_2211, 32'h4433_2211, 3'd4);
    step8("rotr", 1'b1, 2'b01, 1'b1, 8'h5A, 8'h00, 32'h0, 32'h3322_1144, 3'd4);
    step8("rotl", 1'b1, 2'b10, 1'b1, 8'h00, 8'h5A, 32'h0, 32'h4433_2211, 3'd4);
    for (int i = 0; i < 3; i++) begin
      step8("en0", 1'b0, 2'b11, 1'b0, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 32'h4433_2211, 3'd4);
    end
    step8("hold", 1'b1, 2'b00, 1'b1, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 32'h4433_2211, 3'd4);

    clear_pulse("clr_pulse");
    clear_hold("clr_hold");

    // First edge after clear release, then alternating directions.
    step8("r11", 1'b1, 2'b01, 1'b0, 8'h11, 8'hEE, 32'h0, 32'h0000_0011, 3'd1);
    step8("r22", 1'b1, 2'b01, 1'b0, 8'h22, 8'hEE, 32'h0, 32'h0000_1122, 3'd2);
    step8("l33", 1'b1, 2'b10, 1'b0, 8'hEE, 8'h33, 32'h0, 32'h3300_0011, 3'd3);
    step8("r44", 1'b1, 2'b01, 1'b0, 8'h44, 8'hEE, 32'h0, 32'h0000_1144, 3'd4);
    step8("l55", 1'b1, 2'b10, 1'b0, 8'hEE, 8'h55, 32'h0, 32'h5500_0011, 3'd4);
    step8("r66", 1'b1, 2'b01, 1'b0, 8'h66, 8'hEE, 32'h0, 32'h0000_1166, 3'd4);

    // Rotation leaves a partial fill untouched.
    clear_pulse("clr_pulse2");
    step8("r77", 1'b1, 2'b01, 1'b0, 8'h77, 8'h00, 32'h0, 32'h0000_0077, 3'd1);
    step8("rotr_part", 1'b1, 2'b01, 1'b1, 8'hCC, 8'h00, 32'h0, 32'h0000_7700, 3'd1);
    step8("rotl_part", 1'b1, 2'b10, 1'b1, 8'h00, 8'hCC, 32'h0, 32'h0000_0077, 3'd1);

    en8 = 1'b0; en1 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ((q8.size() + q1.size()) != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries want 0", q8.size() + q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
